// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: FSM state type and default divide value shared by clkdiv_prog and its bench.
package clkdiv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    localparam int DIV_DEFAULT = 0;
endpackage

// File: rtl/clkdiv_cnt.sv
// clkdiv_cnt: phase counter; wraps to 0 on terminal count (cnt==lim); ports: clk, rst, en (count), clr (force 0), lim, tc.
module clkdiv_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] lim,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc = cnt_q == lim;
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tc ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: glitch-free even clock divider, clko period 2*(div_cur+1); ports: clk, rst, en, div_in/div_valid/div_ready handshake, clko, running, div_cur.
module clkdiv_prog import clkdiv_pkg::*; #(
    parameter int W       = 8,
    parameter int DEF_DIV = DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         clko,
    output logic         running,
    output logic [W-1:0] div_cur
);
    state_t       state_q, state_d;
    logic         clko_q, clko_d, running_q, running_d, ready_q, ready_d, pend_v_q, pend_v_d;
    logic [W-1:0] div_cur_q, div_cur_d, pend_q, pend_d;
    logic         active, tc, tc_act, hs, apply;
    clkdiv_cnt #(.W(W)) u_cnt (
        .clk(clk), .rst(rst), .en(active), .clr(state_d == IDLE), .lim(div_cur_q), .tc(tc)
    );
    always_comb begin
        active    = state_q != IDLE;
        tc_act    = active && tc;
        hs        = div_valid && ready_q;
        // leaving RUN/STOP is only allowed while low or exactly at the end of the high phase
        state_d   = (!active || en) ? (en ? RUN : IDLE) : (!clko_q || tc) ? IDLE : STOP;
        clko_d    = (state_d == IDLE) ? 1'b0 : clko_q ^ tc_act;
        // pending flag is registered, so a word captured on a boundary waits for the next one
        apply     = pend_v_q && (!active || (tc_act && clko_q));
        div_cur_d = apply ? pend_q : div_cur_q;
        pend_d    = hs ? div_in : pend_q;
        pend_v_d  = hs || (pend_v_q && !apply);
        ready_d   = !pend_v_q && !hs;
        running_d = state_d != IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            clko_q    <= 1'b0;
            running_q <= 1'b0;
            ready_q   <= 1'b1;
            pend_v_q  <= 1'b0;
            pend_q    <= '0;
            div_cur_q <= W'(DEF_DIV);
        end else begin
            state_q   <= state_d;
            clko_q    <= clko_d;
            running_q <= running_d;
            ready_q   <= ready_d;
            pend_v_q  <= pend_v_d;
            pend_q    <= pend_d;
            div_cur_q <= div_cur_d;
        end
    assign clko      = clko_q;
    assign running   = running_q;
    assign div_ready = ready_q;
    assign div_cur   = div_cur_q;
endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: directed self-checking bench for clkdiv_prog.
module tb_clkdiv_prog;
    logic       clk = 0, rst = 1, en = 0, div_valid = 0;
    logic [7:0] div_in = 0;
    logic       div_ready, clko, running;
    logic [7:0] div_cur;
    int         total = 0, bad = 0;
    logic [10:0] pat_a;
    logic [8:0]  pat_b;

    clkdiv_prog #(.W(8), .DEF_DIV(0)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_valid(div_valid),
        .div_ready(div_ready), .clko(clko), .running(running), .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        step(); step();
        chk("rst_clko", clko, 0);
        chk("rst_running", running, 0);
        chk("rst_ready", div_ready, 1);
        chk("rst_div", div_cur, 0);
        rst = 0;
        step();
        chk("idle_clko", clko, 0);
        chk("idle_running", running, 0);
        // CLK/2: rise one cycle after RUN entry
        en = 1;
        step(); chk("run_running", running, 1); chk("run_first", clko, 0);
        step(); chk("div0_c1", clko, 1);
        step(); chk("div0_c2", clko, 0);
        step(); chk("div0_c3", clko, 1);
        step(); chk("div0_c4", clko, 0);
        // change to 3 while running at 0
        div_in = 3; div_valid = 1;
        step(); chk("hs3_ready", div_ready, 0); chk("hs3_clko", clko, 1); chk("hs3_old", div_cur, 0);
        div_valid = 0;
        step(); chk("ap3_div", div_cur, 3); chk("ap3_clko", clko, 0); chk("ap3_ready", div_ready, 0);
        step(); chk("ap3_ready1", div_ready, 1); chk("ap3_lo", clko, 0);
        pat_a = 11'b00111100001;
        for (int i = 0; i < 11; i++) begin
            step(); chk($sformatf("div3_p%0d", i), clko, pat_a[10-i]);
        end
        // change to 2, lands at the 1->0 edge after a full 4-cycle high phase
        div_in = 2; div_valid = 1;
        step(); chk("hs2_ready", div_ready, 0);
        div_valid = 0;
        step();
        step(); chk("hs2_old", div_cur, 3); chk("hs2_hi", clko, 1);
        step(); chk("ap2_div", div_cur, 2); chk("ap2_clko", clko, 0);
        step(); chk("ap2_ready", div_ready, 1); chk("div2_lo1", clko, 0);
        step(); chk("div2_lo2", clko, 0);
        step(); chk("div2_rise", clko, 1);
        // drop EN mid high phase: high completes at 3 cycles
        step(); chk("stop_hi1", clko, 1);
        en = 0;
        step(); chk("stop_hi2", clko, 1); chk("stop_running", running, 1);
        step(); chk("stop_lo", clko, 0); chk("stop_idle", running, 0);
        // drop EN in low phase exactly at the would-be rise: no high pulse
        en = 1;
        step(); chk("lo_run", running, 1); chk("lo_c0", clko, 0);
        step(); chk("lo_c1", clko, 0);
        step(); chk("lo_c2", clko, 0);
        en = 0;
        step(); chk("lo_idle", running, 0); chk("lo_nopulse", clko, 0);
        step(); chk("lo_still", clko, 0);
        // re-raise EN during STOP: waveform undisturbed
        en = 1;
        step(); step(); step();
        step(); chk("re_rise", clko, 1);
        en = 0;
        pat_b = 9'b110001110;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) en = 1;
            chk($sformatf("re_p%0d", i), clko, pat_b[8-i]);
            chk($sformatf("re_run%0d", i), running, 1);
        end
        // handshake on the 1->0 boundary cycle: applies one period later
        for (int i = 0; i < 5; i++) step();
        chk("bd_hi", clko, 1);
        div_in = 1; div_valid = 1;
        step(); chk("bd_fall", clko, 0); chk("bd_keep", div_cur, 2); chk("bd_ready", div_ready, 0);
        div_valid = 0;
        step(); step();
        step(); chk("bd_rise", clko, 1);
        step();
        step(); chk("bd_keep2", div_cur, 2); chk("bd_hi2", clko, 1);
        step(); chk("bd_apply", div_cur, 1); chk("bd_lo", clko, 0);
        step(); chk("bd_ready1", div_ready, 1); chk("div1_lo", clko, 0);
        step(); chk("div1_hi1", clko, 1);
        step(); chk("div1_hi2", clko, 1);
        step(); chk("div1_lo2", clko, 0);
        // asynchronous reset mid-run at DIV=5
        div_in = 5; div_valid = 1;
        step();
        div_valid = 0;
        for (int i = 0; i < 40 && div_cur !== 8'd5; i++) step();
        chk("div5_applied", div_cur, 5);
        for (int i = 0; i < 40 && clko !== 1'b1; i++) step();
        chk("div5_hi", clko, 1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_clko", clko, 0);
        chk("arst_running", running, 0);
        chk("arst_ready", div_ready, 1);
        chk("arst_div", div_cur, 0);
        step();
        rst = 0;
        en = 0;
        step(); chk("post_idle", running, 0); chk("post_clko", clko, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Programmable, glitch-free clock divider that generates the divided clock driving the 9T clock-inverter/buffer tree of a clock domain. Divides CLK by an even ratio set at run time, starts and stops without runt pulses, and applies ratio changes only at whole-period boundaries. All outputs are flop-driven, so the downstream clkinv stage sees a clean, registered waveform.

## Interface
- W, 8: width of divide-control word.
- DEF_DIV, 0: divide value loaded at reset (0 gives CLK/2).
- CLK  input  1  source clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  level request to run the divided clock.
- DIV_IN  input  W  new divide value; output period = 2*(DIV+1) CLK cycles, 50% duty.
- DIV_VALID  input  1  DIV_IN is offered this cycle.
- DIV_READY  output  1  block can accept DIV_IN; transfer when DIV_VALID && DIV_READY.
- CLKO  output  1  divided clock to the clock-inverter tree.
- RUNNING  output  1  high whenever the FSM is not IDLE.
- DIV_CUR  output  W  divide value currently in effect.

## Operation
- Reset values: CLKO=0, RUNNING=0, DIV_READY=1, DIV_CUR=DEF_DIV, counter=0, pending flag=0, state IDLE.
- States: IDLE, RUN, STOP.
- IDLE: CLKO held 0, counter held 0. EN=1 -> RUN next cycle.
- RUN: counter increments each cycle; when counter==DIV_CUR, counter<=0 and CLKO toggles. EN=0 with CLKO=0 -> IDLE (low phase may be truncated; never a short high). EN=0 with CLKO=1 -> STOP.
- STOP: counting continues until the high phase completes (CLKO 1->0), then IDLE. EN=1 while in STOP -> back to RUN, waveform undisturbed.
- Divide update: accepted word goes to a pending register, pending flag set, DIV_READY=0. Pending applied (DIV_CUR<=pending, flag cleared) at the cycle CLKO toggles 1->0 in RUN/STOP, or on the next cycle when in IDLE. DIV_READY returns to 1 the cycle after application.
- Simultaneous: handshake in the same cycle as a 1->0 boundary does not apply at that boundary; applies at the next one. EN and a handshake in the same IDLE cycle: new value applies before the first period starts... only if captured one cycle earlier; otherwise first period uses old DIV_CUR.
- Counter width W; counter never exceeds DIV_CUR (compare is ==, value changes only at counter=0).
- Reset mid-operation: all registers forced to reset values immediately; truncated CLKO high phase on reset is accepted.

## Timing
- CLKO, RUNNING, DIV_READY, DIV_CUR registered; no combinational path from inputs to outputs.
- First CLKO rise occurs DIV_CUR+1 cycles after the cycle RUN is entered.
- High and low phases each exactly DIV_CUR+1 cycles in steady state.
- Ratio change latency: at most one full CLKO period plus one cycle after handshake.
- Stop latency: at most DIV_CUR+1 cycles from EN falling to CLKO=0.

## Structure
- Package clkdiv_pkg: state enum (IDLE, RUN, STOP), DEF_DIV default constant.
- One sub-module: clkdiv_cnt (counter + terminal-count compare, load/clear inputs, tc output); FSM, pending register and handshake in the top.

## Test plan
- Reset then EN=1, DIV=0 -> CLKO toggles every cycle (CLK/2), first rise 1 cycle after RUN; RUNNING=1.
- Handshake DIV_IN=3 while running at DIV=0 -> DIV_READY=0, change lands at next 1->0 edge, then 4-high/4-low periods, DIV_READY=1 one cycle later.
- DIV=2, drop EN mid high phase -> high phase completes at full 3 cycles, CLKO=0, RUNNING=0; drop EN in low phase -> IDLE next cycle, no high pulse.
- EN drop then re-raise during STOP -> no gap or glitch in CLKO, periods stay 6 cycles.
- Handshake coinciding with the 1->0 boundary -> old value kept one more period, applied at following boundary.
- Assert RST mid-run at DIV=5 -> CLKO=0, DIV_CUR=DEF_DIV, DIV_READY=1, RUNNING=0 immediately, asynchronous to CLK.
